fft_sequencer: RTL and testbench

FFT_SEQUENCER -- requirements
Module: fft_sequencer

---
 rtl/fft_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_fft_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_sequencer.sv
// FFT sequencer: scramble handoff, then log2(N) stages of butterfly address generation with an
// in-place write-back delay line. Optional stall input is enabled by defining FFT_SEQ_STALL_EN.
module fft_sequencer #(
  parameter int unsigned FFT_SIZE     = 8,
  parameter int unsigned ADDR_SIZE    = $clog2(FFT_SIZE * 2),
  parameter int unsigned BFLY_LATENCY = 2
) (
  input  logic                                i_CLK,
  input  logic                                i_RST,
  input  logic                                i_start,
  input  logic                                i_scr_done,
  output logic                                o_scr_start,
  output logic                                o_sel,
  output logic                                o_rden,
  output logic                                o_wren,
  output logic [ADDR_SIZE-1:0]                o_rdaddr_A,
  output logic [ADDR_SIZE-1:0]                o_rdaddr_B,
  output logic [ADDR_SIZE-1:0]                o_wraddr_A,
  output logic [ADDR_SIZE-1:0]                o_wraddr_B,
  output logic [$clog2(FFT_SIZE)-2:0]         o_twiddle_idx,
  output logic [$clog2($clog2(FFT_SIZE)):0]   o_stage,
  output logic                                o_busy,
  output logic                                o_done
`ifdef FFT_SEQ_STALL_EN
  ,
  input  logic                                i_stall
`endif
);

  localparam int unsigned Log2N  = $clog2(FFT_SIZE);
  localparam int unsigned KW     = Log2N - 1;
  localparam int unsigned StageW = $clog2(Log2N) + 1;
  localparam int unsigned DrainW = $clog2(BFLY_LATENCY + 1);

  typedef enum logic [2:0] {StIdle, StScramble, StBflyRun, StBflyDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [KW-1:0]       k_q, k_d;
  logic [StageW-1:0]   stage_q, stage_d;
  logic [DrainW-1:0]   drain_q, drain_d;
  logic                scr_start_q, scr_start_d;
  logic [BFLY_LATENCY-1:0] vld_q, vld_d;
  logic [ADDR_SIZE-1:0]    dla_q [BFLY_LATENCY];
  logic [ADDR_SIZE-1:0]    dla_d [BFLY_LATENCY];
  logic [ADDR_SIZE-1:0]    dlb_q [BFLY_LATENCY];
  logic [ADDR_SIZE-1:0]    dlb_d [BFLY_LATENCY];
  logic                stall;

`ifdef FFT_SEQ_STALL_EN
  assign stall = i_stall;
`else
  assign stall = 1'b0;
`endif

  // Butterfly pair address and twiddle index for the current (stage, k); zero outside BFLY_RUN.
  always_comb begin
    int unsigned k_i, s_i, span, pos, a_i, b_i, tw_i;
    k_i  = 32'(k_q);
    s_i  = 32'(stage_q);
    span = 32'd1 << s_i;
    pos  = k_i & (span - 32'd1);
    a_i  = ((k_i >> s_i) << (s_i + 32'd1)) + pos;
    b_i  = a_i + span;
    tw_i = pos << (Log2N - 32'd1 - s_i);
    o_rdaddr_A    = '0;
    o_rdaddr_B    = '0;
    o_twiddle_idx = '0;
    if (state_q == StBflyRun) begin
      o_rdaddr_A    = ADDR_SIZE'(a_i);
      o_rdaddr_B    = ADDR_SIZE'(b_i);
      o_twiddle_idx = (Log2N - 1)'(tw_i);
    end
  end

  // Next-state logic; a stall holds every register at its current value.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    stage_d     = stage_q;
    drain_d     = drain_q;
    scr_start_d = 1'b0;
    if (!stall) begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            state_d     = StScramble;
            scr_start_d = 1'b1;
          end
        end
        StScramble: begin
          if (i_scr_done) begin
            state_d = StBflyRun;
            k_d     = '0;
            stage_d = '0;
          end
        end
        StBflyRun: begin
          k_d = k_q + KW'(1);
          if (k_q == KW'(FFT_SIZE / 2 - 1)) begin
            state_d = StBflyDrain;
            drain_d = '0;
          end
        end
        StBflyDrain: begin
          drain_d = drain_q + DrainW'(1);
          // Leave only once the last read of this stage has been written back.
          if (drain_q == DrainW'(BFLY_LATENCY - 1)) begin
            if (stage_q == StageW'(Log2N - 1)) begin
              state_d = StDone;
            end else begin
              state_d = StBflyRun;
              stage_d = stage_q + StageW'(1);
              k_d     = '0;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
          stage_d = '0;
          k_d     = '0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Read-to-write delay line; bubbles carry zero addresses so idle write addresses read 0.
  always_comb begin
    vld_d = vld_q;
    dla_d = dla_q;
    dlb_d = dlb_q;
    if (!stall) begin
      vld_d[0] = o_rden;
      dla_d[0] = o_rdaddr_A;
      dlb_d[0] = o_rdaddr_B;
      for (int i = 1; i < BFLY_LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        dla_d[i] = dla_q[i-1];
        dlb_d[i] = dlb_q[i-1];
      end
    end
  end

  // Output decode.
  always_comb begin
    o_scr_start = scr_start_q;
    o_sel       = (state_q == StBflyRun) || (state_q == StBflyDrain);
    o_rden      = (state_q == StBflyRun) && !stall;
    o_wren      = vld_q[BFLY_LATENCY-1] && !stall;
    o_wraddr_A  = dla_q[BFLY_LATENCY-1];
    o_wraddr_B  = dlb_q[BFLY_LATENCY-1];
    o_stage     = stage_q;
    o_busy      = (state_q != StIdle);
    o_done      = (state_q == StDone);
  end

  // State registers; reset flushes the delay line so no stale write survives.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_q     <= StIdle;
      k_q         <= '0;
      stage_q     <= '0;
      drain_q     <= '0;
      scr_start_q <= 1'b0;
      vld_q       <= '0;
      for (int i = 0; i < BFLY_LATENCY; i++) begin
        dla_q[i] <= '0;
        dlb_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      stage_q     <= stage_d;
      drain_q     <= drain_d;
      scr_start_q <= scr_start_d;
      vld_q       <= vld_d;
      dla_q       <= dla_d;
      dlb_q       <= dlb_d;
    end
  end

endmodule

// File: tb/tb_fft_sequencer.sv
// Self-checking bench for fft_sequencer (FFT_SIZE=8, BFLY_LATENCY=2).
module tb_fft_sequencer;

  logic       clk = 1'b0;
  logic       i_RST, i_start, i_scr_done, i_stall;
  logic       o_scr_start, o_sel, o_rden, o_wren, o_busy, o_done;
  logic [3:0] o_rdaddr_A, o_rdaddr_B, o_wraddr_A, o_wraddr_B;
  logic [1:0] o_twiddle_idx;
  logic [2:0] o_stage;

  int vectors = 0;
  int miscompares = 0;

  // Expected pair sequence for stages 0, 1, 2 (four pairs each).
  int exp_a [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_b [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  fft_sequencer #(.FFT_SIZE(8), .BFLY_LATENCY(2)) dut (
`ifdef FFT_SEQ_STALL_EN
    .i_stall      (i_stall),
`endif
    .i_CLK        (clk),
    .i_RST        (i_RST),
    .i_start      (i_start),
    .i_scr_done   (i_scr_done),
    .o_scr_start  (o_scr_start),
    .o_sel        (o_sel),
    .o_rden       (o_rden),
    .o_wren       (o_wren),
    .o_rdaddr_A   (o_rdaddr_A),
    .o_rdaddr_B   (o_rdaddr_B),
    .o_wraddr_A   (o_wraddr_A),
    .o_wraddr_B   (o_wraddr_B),
    .o_twiddle_idx(o_twiddle_idx),
    .o_stage      (o_stage),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_RST = 1'b0;
    #3;
    vectors++;
    if ({o_scr_start, o_sel, o_rden, o_wren, o_rdaddr_A, o_rdaddr_B, o_wraddr_A, o_wraddr_B,
         o_twiddle_idx, o_stage, o_busy, o_done} !== '0)
      begin miscompares++; $display("FAIL reset_outputs got busy=%b sel=%b want all 0",
                                    o_busy, o_sel); end
    step();
    i_RST = 1'b1;
    // A stray scramble-done in IDLE must not wake the block.
    i_scr_done = 1'b1;
    step();
    i_scr_done = 1'b0;
    step();
    vectors++;
    if (o_busy !== 1'b0 || o_scr_start !== 1'b0)
      begin miscompares++; $display("FAIL idle_after_reset got busy=%b scr_start=%b want 0 0",
                                    o_busy, o_scr_start); end
  endtask

  // Run start + scramble handshake; leaves the bench sampling the first BFLY_RUN cycle.
  task automatic do_scramble();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    vectors++;
    if (o_scr_start !== 1'b1 || o_busy !== 1'b1 || o_sel !== 1'b0)
      begin miscompares++; $display("FAIL scr_first got start=%b busy=%b sel=%b want 1 1 0",
                                    o_scr_start, o_busy, o_sel); end
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (o_scr_start !== 1'b0 || o_sel !== 1'b0 || o_rden !== 1'b0)
        begin miscompares++; $display("FAIL scr_wait got start=%b sel=%b rden=%b want 0 0 0",
                                      o_scr_start, o_sel, o_rden); end
    end
    i_scr_done = 1'b1;
    step();
    i_scr_done = 1'b0;
  endtask

  task automatic test_transform(input int stall_at, input int stall_len, input bit poke_start);
    int rd_idx = 0;
    int act = 0;
    bit done_seen = 1'b0;
    int wq_a[$], wq_b[$], wq_due[$];
    do_scramble();
    for (int t = 0; t < 80; t++) begin
      i_stall = (t >= stall_at) && (t < stall_at + stall_len);
      i_start = poke_start && (t == 7);
      #1;
      if (o_rden) begin
        vectors++;
        if (rd_idx >= 12) begin
          miscompares++; $display("FAIL extra_read got idx=%0d want <12", rd_idx);
        end else if (o_rdaddr_A !== 4'(exp_a[rd_idx]) || o_rdaddr_B !== 4'(exp_b[rd_idx]) ||
                     o_twiddle_idx !== 2'(exp_tw[rd_idx]) || o_stage !== 3'(rd_idx / 4) ||
                     o_sel !== 1'b1) begin
          miscompares++;
          $display("FAIL read_pair[%0d] got A=%0d B=%0d tw=%0d st=%0d sel=%b want %0d %0d %0d %0d 1",
                   rd_idx, o_rdaddr_A, o_rdaddr_B, o_twiddle_idx, o_stage, o_sel,
                   exp_a[rd_idx], exp_b[rd_idx], exp_tw[rd_idx], rd_idx / 4);
        end
        wq_a.push_back(int'(o_rdaddr_A));
        wq_b.push_back(int'(o_rdaddr_B));
        wq_due.push_back(act + 2);
        rd_idx++;
      end
      if (o_wren) begin
        vectors++;
        if (wq_a.size() == 0) begin
          miscompares++; $display("FAIL unexpected_write got A=%0d want no write", o_wraddr_A);
        end else begin
          int ea, eb, ed;
          ea = wq_a.pop_front();
          eb = wq_b.pop_front();
          ed = wq_due.pop_front();
          if (int'(o_wraddr_A) != ea || int'(o_wraddr_B) != eb || act != ed) begin
            miscompares++;
            $display("FAIL write_pair got A=%0d B=%0d at %0d want %0d %0d at %0d",
                     o_wraddr_A, o_wraddr_B, act, ea, eb, ed);
          end
        end
      end
      if (o_done) begin
        vectors++;
        if (t != 18 + stall_len)
          begin miscompares++; $display("FAIL done_time got %0d want %0d", t, 18 + stall_len); end
        done_seen = 1'b1;
      end
      if (!i_stall) act++;
      if (done_seen) break;
      step();
    end
    i_stall = 1'b0;
    i_start = 1'b0;
    vectors++;
    if (!done_seen) begin miscompares++; $display("FAIL done_timeout got none want o_done"); end
    vectors++;
    if (rd_idx != 12 || wq_a.size() != 0)
      begin miscompares++; $display("FAIL pair_count got reads=%0d pending=%0d want 12 0",
                                    rd_idx, wq_a.size()); end
    step();
    vectors++;
    if (o_done !== 1'b0 || o_busy !== 1'b0)
      begin miscompares++; $display("FAIL after_done got done=%b busy=%b want 0 0",
                                    o_done, o_busy); end
  endtask

  task automatic test_back_to_back();
    test_transform(100, 0, 1'b1);
    test_transform(100, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    do_scramble();
    for (int t = 0; t < 8; t++) step();
    vectors++;
    if (o_stage !== 3'd1 || o_rdaddr_A !== 4'd4 || o_rden !== 1'b1)
      begin miscompares++; $display("FAIL mid_position got st=%0d A=%0d rden=%b want 1 4 1",
                                    o_stage, o_rdaddr_A, o_rden); end
    i_RST = 1'b0;
    #1;
    vectors++;
    if ({o_scr_start, o_sel, o_rden, o_wren, o_rdaddr_A, o_rdaddr_B, o_wraddr_A, o_wraddr_B,
         o_twiddle_idx, o_stage, o_busy, o_done} !== '0)
      begin miscompares++; $display("FAIL mid_reset_outputs got sel=%b wren=%b busy=%b want 0",
                                    o_sel, o_wren, o_busy); end
    step();
    step();
    i_RST = 1'b1;
    for (int t = 0; t < 30; t++) begin
      step();
      if (o_wren || o_busy) bad++;
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL post_reset_activity got %0d want 0", bad); end
  endtask

  initial begin
    i_RST      = 1'b0;
    i_start    = 1'b0;
    i_scr_done = 1'b0;
    i_stall    = 1'b0;
    test_reset();
    test_transform(100, 0, 1'b0);
`ifdef FFT_SEQ_STALL_EN
    test_transform(1, 3, 1'b0);
`endif
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
